// File: rtl/fifo_rd_packer_pkg.sv
// Shared definitions for the FIFO read-side packer.
//   - FSM state encodings and the state_t enum built from them
//   - LANDING_DEPTH: entries in the landing buffer that absorbs the word in
//     flight when the packer stalls
//   - clog2: constant-evaluable ceiling log2, valid for n >= 1
package fifo_rd_packer_pkg;

    localparam logic [1:0] ENC_IDLE  = 2'd0;
    localparam logic [1:0] ENC_RUN   = 2'd1;
    localparam logic [1:0] ENC_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ENC_IDLE,
        RUN   = ENC_RUN,
        DRAIN = ENC_DRAIN
    } state_t;

    // One word can be in flight from the FIFO while one more was already
    // in flight the previous cycle, so two entries are enough to never drop.
    localparam int LANDING_DEPTH = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_rd_packer_skid.sv
// Small landing buffer for registered-read FIFO consumers.
// A word arriving while the consumer cannot take it is pushed here and is
// drained in order ahead of any later arrival.
// Ports:
//   I_clk, I_rst_n  clock, asynchronous active-low reset
//   I_push          write I_push_data at the tail (caller guarantees not full)
//   I_pop           drop the head entry (caller guarantees not empty)
//   O_head          current head entry
//   O_count         number of stored entries, 0..DEPTH
module fifo_rd_packer_skid
    import fifo_rd_packer_pkg::*;
#(
    parameter  int DSIZE = 8,
    parameter  int DEPTH = LANDING_DEPTH,
    localparam int CW    = clog2(DEPTH + 1)
) (
    input  logic             I_clk,
    input  logic             I_rst_n,
    input  logic             I_push,
    input  logic [DSIZE-1:0] I_push_data,
    input  logic             I_pop,
    output logic [DSIZE-1:0] O_head,
    output logic [CW-1:0]    O_count
);

    localparam int            PW       = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [DSIZE-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    assign O_head = mem[rd_ptr];

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            O_count <= '0;
        end else begin
            if (I_push) begin
                mem[wr_ptr] <= I_push_data;
                wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (I_pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            O_count <= O_count + CW'(I_push) - CW'(I_pop);
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-side consumer of the asynchronous FIFO (runs on the FIFO read clock).
// Pops DSIZE-bit words, packs RATIO of them into one beat (first word in the
// least significant slot) and emits frames of I_frame_len beats on a
// valid/ready stream, flagging the last beat.
// Ports:
//   I_clk, I_rst_n          clock, asynchronous active-low reset
//   I_start, I_frame_len    start pulse and frame length in beats
//   O_busy, O_done          frame in progress / one-cycle completion pulse
//   O_fifo_rinc             pop request to the FIFO
//   I_fifo_rempty           FIFO empty flag
//   I_fifo_rdata            FIFO read data, valid the cycle after a pop
//   O_valid, I_ready        output handshake
//   O_data, O_last          packed beat and final-beat marker
module fifo_rd_packer
    import fifo_rd_packer_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int RATIO = 4,
    parameter int LEN_W = 16
) (
    input  logic                   I_clk,
    input  logic                   I_rst_n,
    input  logic                   I_start,
    input  logic [LEN_W-1:0]       I_frame_len,
    output logic                   O_busy,
    output logic                   O_done,
    output logic                   O_fifo_rinc,
    input  logic                   I_fifo_rempty,
    input  logic [DSIZE-1:0]       I_fifo_rdata,
    output logic                   O_valid,
    input  logic                   I_ready,
    output logic [DSIZE*RATIO-1:0] O_data,
    output logic                   O_last
);

    localparam int             PCW       = (clog2(RATIO) > 0) ? clog2(RATIO) : 1;
    localparam int             WLW       = LEN_W + clog2(RATIO);
    localparam int             LCW       = clog2(LANDING_DEPTH + 1);
    localparam int             OW        = DSIZE * RATIO;
    localparam logic [PCW-1:0] PACK_LAST = PCW'(RATIO - 1);

    state_t           state_q, state_nxt;
    logic             inflight_q;
    logic [WLW-1:0]   words_left;
    logic [LEN_W-1:0] beats_left;
    logic             done_q;
    logic             rd_pop;
    logic             start_frame, zero_frame, frame_end;

    logic [LCW-1:0]   land_cnt;
    logic [DSIZE-1:0] land_data;
    logic             land_push, land_pop;
    logic             src_vld;
    logic [DSIZE-1:0] src_data;

    logic [PCW-1:0]   pack_cnt;
    logic [OW-1:0]    pack_p1;
    logic [OW-1:0]    beat_full;
    logic             pack_take, beat_load, beat_is_last;

    logic             vld_p2, last_p2;
    logic [OW-1:0]    data_p2;
    logic             out_free, accept;

    // Pop request uses only registered state and the empty flag; the
    // landing buffer guarantees room for every word already requested.
    assign rd_pop = (state_q == RUN) && (words_left != '0) && !I_fifo_rempty &&
                    ((int'(land_cnt) + int'(inflight_q)) < LANDING_DEPTH);

    // ---- stage p0: FIFO read data / landing buffer ----
    assign src_vld  = (land_cnt != '0) || inflight_q;
    assign src_data = (land_cnt != '0) ? land_data : I_fifo_rdata;

    assign out_free     = !vld_p2 || I_ready;
    assign accept       = vld_p2 && I_ready;
    assign pack_take    = src_vld && ((pack_cnt != PACK_LAST) || out_free);
    assign beat_load    = pack_take && (pack_cnt == PACK_LAST);
    assign land_pop     = pack_take && (land_cnt != '0);
    // The arriving word bypasses the buffer only if the buffer is empty and
    // the packer takes it this cycle; otherwise it lands.
    assign land_push    = inflight_q && !(pack_take && (land_cnt == '0));

    // Beats still unaccepted after this cycle's handshake; the beat being
    // loaded is the last one when it is the only one left.
    assign beat_is_last = accept ? (beats_left == LEN_W'(2)) : (beats_left == LEN_W'(1));

    fifo_rd_packer_skid #(
        .DSIZE (DSIZE),
        .DEPTH (LANDING_DEPTH)
    ) u_land (
        .I_clk       (I_clk),
        .I_rst_n     (I_rst_n),
        .I_push      (land_push),
        .I_push_data (I_fifo_rdata),
        .I_pop       (land_pop),
        .O_head      (land_data),
        .O_count     (land_cnt)
    );

    // ---- stage p1: packer ----
    always_comb begin
        beat_full = pack_p1;
        beat_full[DSIZE*(RATIO-1) +: DSIZE] = src_data;
    end

    always_comb begin
        state_nxt   = state_q;
        start_frame = 1'b0;
        zero_frame  = 1'b0;
        frame_end   = 1'b0;
        case (state_q)
            IDLE: begin
                if (I_start) begin
                    if (I_frame_len != '0) begin
                        start_frame = 1'b1;
                        state_nxt   = RUN;
                    end else begin
                        zero_frame  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (rd_pop && (words_left == WLW'(1))) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (accept && last_p2) begin
                    frame_end = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            words_left <= '0;
            beats_left <= '0;
            done_q     <= 1'b0;
            pack_cnt   <= '0;
            pack_p1    <= '0;
            vld_p2     <= 1'b0;
            data_p2    <= '0;
            last_p2    <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            inflight_q <= rd_pop;
            done_q     <= zero_frame || frame_end;

            if (start_frame) begin
                words_left <= WLW'(I_frame_len) * WLW'(RATIO);
                beats_left <= I_frame_len;
            end else begin
                if (rd_pop) words_left <= words_left - 1'b1;
                if (accept) beats_left <= beats_left - 1'b1;
            end

            if (pack_take) begin
                pack_cnt <= (pack_cnt == PACK_LAST) ? '0 : pack_cnt + 1'b1;
                for (int i = 0; i < RATIO; i++) begin
                    if (pack_cnt == PCW'(i)) pack_p1[i*DSIZE +: DSIZE] <= src_data;
                end
            end

            // ---- stage p2: output register ----
            if (beat_load) begin
                vld_p2  <= 1'b1;
                data_p2 <= beat_full;
                last_p2 <= beat_is_last;
            end else if (accept) begin
                vld_p2  <= 1'b0;
                last_p2 <= 1'b0;
            end
        end
    end

    assign O_busy      = (state_q != IDLE);
    assign O_done      = done_q;
    assign O_fifo_rinc = rd_pop;
    assign O_valid     = vld_p2;
    assign O_data      = data_p2;
    assign O_last      = last_p2;

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
Read-side consumer of the asynchronous FIFO, in the FIFO's read clock domain. It pops DSIZE-bit words through the FIFO's rinc/rempty/rdata interface. It packs RATIO consecutive words into one output beat and presents the beats on a valid/ready stream. Transfers are framed: each frame is a programmed number of output beats, and the last beat is flagged.

Parameters:
DSIZE, 8, width of one FIFO word
RATIO, 4, FIFO words per output beat (>=1)
LEN_W, 16, width of the frame-length field (in output beats)

Ports:
I_clk  in  1  clock; same clock as the FIFO I_rclk
I_rst_n  in  1  asynchronous active-low reset
I_start  in  1  one-cycle pulse; sample I_frame_len and begin a frame
I_frame_len  in  LEN_W  output beats in the frame
O_busy  out  1  frame in progress
O_done  out  1  one-cycle pulse after the frame's last beat is accepted
O_fifo_rinc  out  1  pop request to the FIFO I_rinc
I_fifo_rempty  in  1  from the FIFO O_rempty
I_fifo_rdata  in  DSIZE  from the FIFO O_rdata
O_valid  out  1  output beat valid
I_ready  in  1  downstream accept
O_data  out  DSIZE*RATIO  packed beat; first popped word in bits [DSIZE-1:0]
O_last  out  1  qualifies the final beat of the frame

Behaviour:
- Clock and reset: one clock, I_clk. Reset I_rst_n is asynchronous and active-low.
- Reset values: O_busy=0, O_done=0, O_fifo_rinc=0, O_valid=0, O_data=0, O_last=0. All counters, landing buffer and FSM are cleared; FSM goes to IDLE.
- FIFO read contract:
  - A pop occurs in cycle t when O_fifo_rinc=1 and I_fifo_rempty=0.
  - The popped word appears on I_fifo_rdata in cycle t+1 and is captured at the end of t+1.
  - An inflight_q flag tracks this one-cycle latency.
- O_fifo_rinc is combinational from registered state and I_fifo_rempty only. It must not depend on I_ready. It asserts when all of the following hold:
  - state==RUN
  - words_left!=0
  - I_fifo_rempty==0
  - land_cnt + inflight_q < 2
- Landing buffer:
  - Two-entry FIFO of DSIZE words; land_cnt is 0..2.
  - It absorbs the word in flight when the packer stalls, so no popped word is ever lost.
- Packer:
  - Shift/accumulate register with pack_cnt 0..RATIO-1.
  - Takes one word per cycle from the landing buffer, or bypasses it when the buffer is empty.
  - On the RATIO-th word it transfers the assembled beat to the output register only if the output register is empty or is being accepted this cycle. Otherwise the packer holds and stops taking words.
  - Sustained throughput is one word per cycle when the FIFO is non-empty and I_ready=1.
- Output register:
  - O_valid stays asserted until accepted (O_valid & I_ready).
  - O_data and O_last are stable while O_valid=1 and I_ready=0.
  - O_last=1 when the beat counter reaches frame_len-1.
- Counters:
  - words_left (LEN_W+clog2(RATIO) bits) loads frame_len*RATIO on start and decrements per pop.
  - beats_left (LEN_W bits) decrements per accepted beat.
- FSM:
  - IDLE: on I_start with frame_len!=0, go to RUN and set O_busy=1. With frame_len==0, stay in IDLE and pulse O_done in the next cycle; no pops occur.
  - RUN: when words_left reaches 0, go to DRAIN.
  - DRAIN: no pops. When the O_last beat is accepted, go to IDLE, set O_busy=0 and pulse O_done in the following cycle.
- I_start is ignored while O_busy=1.
- Frame boundary: the block never pops more than frame_len*RATIO words. Surplus words remain in the FIFO for the next frame.
- An empty FIFO mid-frame only stalls the block. No timeout.
- Reset mid-frame: all state is cleared immediately. Words already popped are discarded. The FIFO read side must be reset by the same reset event; the system reset synchronizer provides this.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE/RUN/DRAIN as localparams)
  - clog2 function
  - LANDING_DEPTH=2 constant
- One sub-module is natural: fifo_rd_packer_skid, the 2-entry landing buffer with push/pop/count. It is reusable for other registered-read FIFO consumers.
- The packer and FSM stay in the top module.

Test Plan:
1. RATIO=4, FIFO preloaded with 0x01..0x08, frame_len=2, I_ready=1 -> beats 0x04030201, then 0x08070605 with O_last=1; exactly 8 pops; O_done pulse; O_busy falls.
2. FIFO written sporadically (random gaps of 0-5 cycles), frame_len=3 -> no O_fifo_rinc while rempty=1; 3 correct beats in order.
3. Continuous data, I_ready low for 10 cycles mid-frame -> pops stop once the landing buffer, packer and output are full; O_data is held stable; no word is lost or duplicated after I_ready returns.
4. frame_len=0 -> O_done pulse one cycle after I_start; zero pops; O_valid is never asserted.
5. FIFO holds 12 words, frame_len=2 -> exactly 8 pops; 4 words remain; a second frame with frame_len=1 returns 0x0C0B0A09.
6. I_rst_n asserted mid-frame, asynchronous to the clock edge -> all outputs go to reset values immediately; after reset and a FIFO reset, a new frame completes correctly.
